// File: rtl/up_core_gen.sv
// up_core_gen: parametrised two-phase accumulator core with call stack,
// run/hold control and an absorbing fault state.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   run               1 = execute, 0 = hold in FETCH (sampled in FETCH only)
//   rom_addr/rom_data program ROM (address = pc, data = {opcode, operand})
//   ram_addr/ram_rdata/ram_wdata/ram_we  data RAM (zero-wait read)
//   pushbuttons       input port read by IN
//   out_port          output latch written by OUT
//   phase, instr, oprnd, accu, c_flag, z_flag, sp, fault  visible core state
module up_core_gen #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W+3:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] pushbuttons,
  output logic [DATA_W-1:0] out_port,
  output logic              phase,
  output logic [3:0]        instr,
  output logic [DATA_W-1:0] oprnd,
  output logic [DATA_W-1:0] accu,
  output logic              c_flag,
  output logic              z_flag,
  output logic [SP_W-1:0]   sp,
  output logic              fault
);

  // Stack storage is sized to the full sp index range so sp can index it directly.
  localparam int unsigned STK_N = 1 << SP_W;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LD    = 4'h2;
  localparam logic [3:0] OP_ST    = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUBI  = 4'h6;
  localparam logic [3:0] OP_CMPI  = 4'h7;
  localparam logic [3:0] OP_NANDI = 4'h8;
  localparam logic [3:0] OP_IN    = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_JC    = 4'hC;
  localparam logic [3:0] OP_JNZ   = 4'hD;
  localparam logic [3:0] OP_CALL  = 4'hE;
  localparam logic [3:0] OP_RET   = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   opr_q, opr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]   stack_q [STK_N];
  logic                push_c;

  logic [DATA_W-1:0]   imm_c;
  logic [DATA_W-1:0]   add_b_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   diff_c;
  logic                ge_c;
  logic                full_c;
  logic                empty_c;

  // Shared ALU datapath; ADD takes RAM data, every other arithmetic op the immediate.
  assign imm_c   = opr_q[DATA_W-1:0];
  assign add_b_c = (op_q == OP_ADD) ? ram_rdata : imm_c;
  assign sum_c   = {1'b0, acc_q} + {1'b0, add_b_c};
  assign diff_c  = acc_q - imm_c;
  assign ge_c    = (acc_q >= imm_c);
  assign full_c  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_c = (sp_q == '0);

  // State register and architectural state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      op_q    <= '0;
      opr_q   <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      sp_q    <= '0;
      for (int i = 0; i < STK_N; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
      sp_q    <= sp_d;
      // Return address is the already-incremented pc.
      if (push_c) stack_q[sp_q] <= pc_q;
    end
  end

  // Next-state and instruction execution.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    out_d   = out_q;
    sp_d    = sp_q;
    push_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          op_d    = rom_data[ADDR_W+3:ADDR_W];
          opr_d   = rom_data[ADDR_W-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_NOP, OP_ST: ;
          OP_LDI: begin
            acc_d = imm_c;
            z_d   = (imm_c == '0);
          end
          OP_LD: begin
            acc_d = ram_rdata;
            z_d   = (ram_rdata == '0);
          end
          OP_ADDI, OP_ADD: begin
            {c_d, acc_d} = sum_c;
            z_d          = (sum_c[DATA_W-1:0] == '0);
          end
          OP_SUBI: begin
            acc_d = diff_c;
            c_d   = ge_c;
            z_d   = (diff_c == '0);
          end
          OP_CMPI: begin
            c_d = ge_c;
            z_d = (diff_c == '0);
          end
          OP_NANDI: begin
            acc_d = ~(acc_q & imm_c);
            z_d   = ((acc_q & imm_c) == {DATA_W{1'b1}});
          end
          OP_IN: begin
            acc_d = pushbuttons;
            z_d   = (pushbuttons == '0);
          end
          OP_OUT: out_d = acc_q;
          OP_JMP: pc_d = opr_q;
          OP_JC:  if (c_q) pc_d = opr_q;
          OP_JNZ: if (!z_q) pc_d = opr_q;
          // Stack violations freeze everything and park the core in FAULT.
          OP_CALL: begin
            if (full_c) begin
              state_d = S_FAULT;
            end else begin
              push_c = 1'b1;
              sp_d   = sp_q + SP_W'(1);
              pc_d   = opr_q;
            end
          end
          OP_RET: begin
            if (empty_c) begin
              state_d = S_FAULT;
            end else begin
              sp_d = sp_q - SP_W'(1);
              pc_d = stack_q[sp_q - SP_W'(1)];
            end
          end
          default: ;
        endcase
      end
      S_FAULT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobe is decoded from state and gated by reset so it drops immediately.
  assign ram_we    = (state_q == S_EXEC) && (op_q == OP_ST) && !reset;
  assign rom_addr  = pc_q;
  assign ram_addr  = opr_q;
  assign ram_wdata = acc_q;
  assign out_port  = out_q;
  assign phase     = (state_q == S_EXEC);
  assign instr     = op_q;
  assign oprnd     = opr_q[DATA_W-1:0];
  assign accu      = acc_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign sp        = sp_q;
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_up_core_gen.sv
// Scoreboard bench for up_core_gen: an instruction-level reference model
// predicts architectural state after each instruction; a monitor pops and
// compares at every retirement.
module tb_up_core_gen;

  localparam int DW  = 4;
  localparam int AW  = 12;
  localparam int SD  = 4;
  localparam int SPW = 3;
  localparam int NMEM = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          run;
  logic          run_dir = 1'b0;
  logic          run_rnd = 1'b1;
  logic          rand_run = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [AW+3:0] rom_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] pb_v = '0;
  logic [DW-1:0] out_port;
  logic          phase;
  logic [3:0]    instr;
  logic [DW-1:0] oprnd;
  logic [DW-1:0] accu;
  logic          c_flag;
  logic          z_flag;
  logic [SPW-1:0] sp;
  logic          fault;

  logic [15:0]   rom      [NMEM];
  logic [DW-1:0] ram      [NMEM];
  logic [DW-1:0] ram_init [NMEM];
  int            wr_count = 0;

  up_core_gen #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clock(clock), .reset(reset), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .pushbuttons(pb_v), .out_port(out_port),
    .phase(phase), .instr(instr), .oprnd(oprnd), .accu(accu),
    .c_flag(c_flag), .z_flag(z_flag), .sp(sp), .fault(fault)
  );

  always #5 clock = ~clock;

  assign run       = rand_run ? run_rnd : run_dir;
  assign rom_data  = rom[rom_addr];
  assign ram_rdata = ram[ram_addr];

  // RAM: reloaded from ram_init while reset is held, otherwise written by the core.
  always @(posedge clock) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      wr_count <= wr_count + 1;
    end else if (reset) begin
      for (int i = 0; i < NMEM; i++) ram[i] <= ram_init[i];
    end
  end

  always @(posedge clock) run_rnd <= ($urandom_range(0, 3) != 0);

  typedef struct {
    int pc; int acc; int c; int z; int outp; int sp; int fault;
    int we; int waddr; int wdata; int op; int imm;
  } rec_t;

  rec_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pc, m_acc, m_c, m_z, m_out, m_fault;
  int m_stack[$];
  int m_ram [NMEM];

  task automatic model_init();
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_out = 0; m_fault = 0;
    m_stack.delete();
    for (int i = 0; i < NMEM; i++) m_ram[i] = int'(ram_init[i]);
  endtask

  task automatic m_step();
    rec_t r;
    int w, op, opr, imm, s;
    w   = int'(rom[m_pc]);
    op  = (w >> 12) & 15;
    opr = w & 4095;
    imm = opr & 15;
    r = '{default: 0};
    r.op = op; r.imm = imm;
    m_pc = (m_pc + 1) % NMEM;
    case (op)
      1:  begin m_acc = imm; m_z = int'(m_acc == 0); end
      2:  begin m_acc = m_ram[opr]; m_z = int'(m_acc == 0); end
      3:  begin m_ram[opr] = m_acc; r.we = 1; r.waddr = opr; r.wdata = m_acc; end
      4:  begin s = m_acc + imm; m_c = int'(s > 15); m_acc = s % 16; m_z = int'(m_acc == 0); end
      5:  begin s = m_acc + m_ram[opr]; m_c = int'(s > 15); m_acc = s % 16; m_z = int'(m_acc == 0); end
      6:  begin m_c = int'(m_acc >= imm); m_acc = (m_acc - imm + 16) % 16; m_z = int'(m_acc == 0); end
      7:  begin m_c = int'(m_acc >= imm); m_z = int'(m_acc == imm); end
      8:  begin m_acc = 15 - (m_acc & imm); m_z = int'(m_acc == 0); end
      9:  begin m_acc = int'(pb_v); m_z = int'(m_acc == 0); end
      10: m_out = m_acc;
      11: m_pc = opr;
      12: if (m_c != 0) m_pc = opr;
      13: if (m_z == 0) m_pc = opr;
      14: begin
        if (m_stack.size() == SD) m_fault = 1;
        else begin m_stack.push_back(m_pc); m_pc = opr; end
      end
      15: begin
        if (m_stack.size() == 0) m_fault = 1;
        else m_pc = m_stack.pop_back();
      end
      default: ;
    endcase
    r.pc = m_pc; r.acc = m_acc; r.c = m_c; r.z = m_z; r.outp = m_out;
    r.sp = m_stack.size(); r.fault = m_fault;
    q.push_back(r);
  endtask

  // ---------------- monitor ----------------
  int prev_phase = 0;
  int s_we = 0, s_addr = 0, s_wd = 0;

  always @(negedge clock) begin
    rec_t r;
    if (reset) begin
      prev_phase = 0;
      s_we = 0;
    end else begin
      if (phase) begin
        s_we = int'(ram_we); s_addr = int'(ram_addr); s_wd = int'(ram_wdata);
        if (q.size() > 0) begin
          chk("instr", int'(instr), q[0].op);
          chk("oprnd", int'(oprnd), q[0].imm);
        end
      end else if (prev_phase == 1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL retire: core retired an instruction with no prediction pending (pc=%0d)", rom_addr);
        end else begin
          r = q.pop_front();
          chk("pc", int'(rom_addr), r.pc);
          chk("accu", int'(accu), r.acc);
          chk("c_flag", int'(c_flag), r.c);
          chk("z_flag", int'(z_flag), r.z);
          chk("out_port", int'(out_port), r.outp);
          chk("sp", int'(sp), r.sp);
          chk("fault", int'(fault), r.fault);
          chk("ram_we", s_we, r.we);
          if (r.we != 0) begin
            chk("ram_addr", s_addr, r.waddr);
            chk("ram_wdata", s_wd, r.wdata);
          end
        end
      end
      prev_phase = int'(phase);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] ins(input int op, input int opr);
    return 16'(((op & 15) << 12) | (opr & 4095));
  endfunction

  task automatic prog_reset();
    reset = 1'b1; rand_run = 1'b0; run_dir = 1'b0;
    repeat (2) @(posedge clock);
    q.delete();
    for (int i = 0; i < NMEM; i++) begin rom[i] = '0; ram_init[i] = '0; end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clock); #1; k++;
    end
    run_dir = 1'b0; rand_run = 1'b0;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d predictions still pending after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  // ROM/RAM must be loaded before calling; runs n instructions (or to fault).
  task automatic run_prog(input int n, input logic rnd);
    model_init();
    for (int i = 0; i < n && m_fault == 0; i++) m_step();
    @(posedge clock); #2;
    reset = 1'b0; run_dir = 1'b1; rand_run = rnd;
    wait_drain(n * 12 + 50);
    repeat (3) @(negedge clock);
    chk("hold pc", int'(rom_addr), m_pc);
    chk("hold phase", int'(phase), 0);
    if (m_fault != 0) begin
      run_dir = 1'b1;
      repeat (4) @(negedge clock);
      chk("fault sticky", int'(fault), 1);
      chk("fault pc", int'(rom_addr), m_pc);
      chk("fault sp", int'(sp), m_stack.size());
      chk("fault phase", int'(phase), 0);
      run_dir = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < NMEM; i++) begin rom[i] = '0; ram_init[i] = '0; end
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst pc", int'(rom_addr), 0);
    chk("rst phase", int'(phase), 0);
    chk("rst instr", int'(instr), 0);
    chk("rst oprnd", int'(oprnd), 0);
    chk("rst accu", int'(accu), 0);
    chk("rst c", int'(c_flag), 0);
    chk("rst z", int'(z_flag), 0);
    chk("rst out", int'(out_port), 0);
    chk("rst sp", int'(sp), 0);
    chk("rst fault", int'(fault), 0);
    chk("rst ram_we", int'(ram_we), 0);

    // run=0 out of reset: core must stay parked at pc 0
    rom[0] = ins(1, 5);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle pc", int'(rom_addr), 0);
    chk("idle phase", int'(phase), 0);
    chk("idle accu", int'(accu), 0);

    // LDI 7; ADDI B
    prog_reset();
    rom[0] = ins(1, 7); rom[1] = ins(4, 11);
    run_prog(2, 1'b0);
    chk("p1 accu", int'(accu), 2);
    chk("p1 c", int'(c_flag), 1);
    chk("p1 z", int'(z_flag), 0);
    chk("p1 pc", int'(rom_addr), 2);

    // SUBI to zero, then CMPI with borrow
    prog_reset();
    rom[0] = ins(1, 5); rom[1] = ins(6, 5); rom[2] = ins(1, 5); rom[3] = ins(7, 6);
    run_prog(4, 1'b0);
    chk("p2 accu", int'(accu), 5);
    chk("p2 c", int'(c_flag), 0);

    // store then reload through RAM
    prog_reset();
    rom[0] = ins(1, 9); rom[1] = ins(3, 12'h123); rom[2] = ins(1, 0); rom[3] = ins(2, 12'h123);
    run_prog(4, 1'b0);
    chk("p3 accu", int'(accu), 9);

    // IN/OUT and taken JNZ
    prog_reset();
    pb_v = 4'b0110;
    rom[0] = ins(9, 0); rom[1] = ins(10, 0); rom[2] = ins(13, 12'h040);
    run_prog(3, 1'b0);
    chk("p4 out", int'(out_port), 6);
    chk("p4 pc", int'(rom_addr), 12'h040);

    // JNZ not taken after zero input
    prog_reset();
    pb_v = 4'b0000;
    rom[0] = ins(9, 0); rom[1] = ins(13, 12'h080);
    run_prog(2, 1'b0);
    chk("p5 pc", int'(rom_addr), 2);

    // four nested calls and returns
    prog_reset();
    rom[0] = ins(14, 12'h100); rom[12'h100] = ins(14, 12'h200);
    rom[12'h200] = ins(14, 12'h300); rom[12'h300] = ins(14, 12'h400);
    rom[12'h400] = ins(15, 0); rom[12'h301] = ins(15, 0);
    rom[12'h201] = ins(15, 0); rom[12'h101] = ins(15, 0);
    run_prog(9, 1'b0);
    chk("p6 pc", int'(rom_addr), 2);
    chk("p6 sp", int'(sp), 0);

    // fifth nested call overflows
    prog_reset();
    rom[0] = ins(14, 12'h100); rom[12'h100] = ins(14, 12'h200);
    rom[12'h200] = ins(14, 12'h300); rom[12'h300] = ins(14, 12'h400);
    rom[12'h400] = ins(14, 12'h500);
    run_prog(5, 1'b0);
    chk("p7 fault", int'(fault), 1);
    chk("p7 sp", int'(sp), 4);
    chk("p7 pc", int'(rom_addr), 12'h401);

    // return with empty stack
    prog_reset();
    rom[0] = ins(15, 0);
    run_prog(1, 1'b0);
    chk("p8 fault", int'(fault), 1);

    // pc wraps from the last address to 0
    prog_reset();
    rom[0] = ins(11, 12'hFFF); rom[12'hFFF] = ins(1, 3);
    run_prog(3, 1'b0);
    chk("p9 pc", int'(rom_addr), 12'hFFF);

    // run drops during EXEC: instruction completes, core parks at next pc
    prog_reset();
    rom[0] = ins(1, 3); rom[1] = ins(4, 1);
    model_init(); m_step();
    @(posedge clock); #2;
    reset = 1'b0; run_dir = 1'b1;
    @(posedge clock); @(negedge clock); #1;
    run_dir = 1'b0;
    repeat (6) @(negedge clock);
    chk("hold2 pc", int'(rom_addr), 1);
    chk("hold2 accu", int'(accu), 3);
    chk("hold2 phase", int'(phase), 0);
    chk("hold2 pending", q.size(), 0);

    // reset asserted in the EXEC cycle of ST
    prog_reset();
    rom[0] = ins(1, 9); rom[1] = ins(3, 12'h123);
    ram_init[12'h123] = 4'd5;
    model_init(); m_step();
    @(posedge clock); #2;
    reset = 1'b0; run_dir = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("st we", int'(ram_we), 1);
    chk("st wdata", int'(ram_wdata), 9);
    w0 = wr_count;
    reset = 1'b1;
    #1;
    chk("rst st we", int'(ram_we), 0);
    chk("rst st phase", int'(phase), 0);
    chk("rst st accu", int'(accu), 0);
    chk("rst st pc", int'(rom_addr), 0);
    chk("rst st instr", int'(instr), 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst st writes", wr_count, w0);
    chk("rst st ram", int'(ram[12'h123]), 5);

    // randomized programs with random run stalls
    for (int p = 0; p < 8; p++) begin
      int op;
      prog_reset();
      pb_v = 4'($urandom_range(0, 15));
      for (int i = 0; i < NMEM; i++) begin
        op = $urandom_range(0, 15);
        if (op >= 14 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 13);
        rom[i] = ins(op, $urandom_range(0, 4095));
        ram_init[i] = 4'($urandom_range(0, 15));
      end
      run_prog(150, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_core_gen.md
# up_core_gen

Parametrised two-phase accumulator microprocessor core, the next generation of the team's 4-bit/12-bit-PC processor. It generalises data width, address width and call-stack depth. It adds a hardware call/return stack, a run/hold control and a fault state. ROM and RAM are external; the core drives their addresses and consumes their combinational read data. It sits between the program ROM, data RAM, pushbutton inputs and the output latch in the top-level processor.

## Interface
- DATA_W, 4, accumulator/immediate/IO width; legal range 1..ADDR_W
- ADDR_W, 12, program and data address width
- STACK_DEPTH, 4, call-stack entries (≥1); SP_W = clog2(STACK_DEPTH+1)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  1 = execute; 0 = hold in FETCH; sampled in FETCH only
- rom_addr  out  ADDR_W  = pc
- rom_data  in  4+ADDR_W  {opcode[3:0], operand[ADDR_W-1:0]}, combinational from rom_addr
- ram_addr  out  ADDR_W  = IR operand
- ram_rdata  in  DATA_W  combinational RAM read data
- ram_wdata  out  DATA_W  = accu
- ram_we  out  1  write strobe, combinational from state
- pushbuttons  in  DATA_W  input port
- out_port  out  DATA_W  output latch
- phase  out  1  0 = FETCH, 1 = EXEC
- instr  out  4  IR opcode
- oprnd  out  DATA_W  IR operand[DATA_W-1:0]
- accu  out  DATA_W  accumulator
- c_flag, z_flag  out  1 each  carry, zero
- sp  out  SP_W  stack occupancy
- fault  out  1  stack over/underflow; core halted

## Operation
- States: FETCH, EXEC, FAULT.
- FETCH, run=1: IR <= rom_data; pc <= pc+1 mod 2^ADDR_W; next state EXEC.
- FETCH, run=0: no state change.
- EXEC: execute the IR, then go to FETCH. EXEC always completes, whatever run is.
- FAULT: absorbing state. Only reset leaves it.
- imm = operand[DATA_W-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 LD: acc=ram_rdata.
  - 3 ST: ram_we=1.
  - 4 ADDI: {C,acc}=acc+imm.
  - 5 ADD: {C,acc}=acc+ram_rdata.
  - 6 SUBI: acc=acc−imm; C=1 iff acc≥imm (no borrow).
  - 7 CMPI: flags as SUBI; acc unchanged.
  - 8 NANDI: acc=~(acc&imm).
  - 9 IN: acc=pushbuttons.
  - A OUT: out_port=acc.
  - B JMP: pc=operand.
  - C JC: pc=operand if C.
  - D JNZ: pc=operand if !Z.
  - E CALL: push pc (already incremented); pc=operand.
  - F RET: pop into pc.
- Z = (result==0). Z is updated by opcodes 1,2,4,5,6,7,8,9. C is updated by 4,5,6,7 only. All other opcodes leave the flags unchanged.
- Arithmetic is DATA_W-bit with wraparound. C is bit DATA_W of the (DATA_W+1)-bit sum.
- CALL with sp==STACK_DEPTH, or RET with sp==0:
  - enter FAULT, fault=1;
  - pc, acc, flags and stack are unchanged;
  - no push or pop occurs.

## Timing
- Reset values: pc=0, phase=0, IR=0, accu=0, c_flag=0, z_flag=0, out_port=0, sp=0, fault=0, ram_we=0.
- Each instruction takes exactly 2 cycles with run held high: FETCH edge, then EXEC edge. Results are visible after the EXEC edge.
- ram_we is high for exactly the EXEC cycle of ST. It is combinational, so an asserted reset drops it immediately.
- LD/ADD sample ram_rdata at the EXEC edge (zero-wait RAM).
- PC wrap: pc=2^ADDR_W−1 fetches and then becomes 0.
- run falling in EXEC: the current instruction completes, then the core holds in FETCH with pc pointing at the next instruction.
- Reset mid-EXEC: the instruction is abandoned, no write occurs, and all state returns to reset values.
- In FAULT: phase=0, ram_we=0, and all outputs hold.

## Test plan
- Reset, ROM {LDI 7, ADDI B} with DATA_W=4 -> after cycle 2: accu=7, Z=0. After cycle 4: accu=2, C=1, Z=0. pc=2.
- acc=5; SUBI 5 -> accu=0, Z=1, C=1. LDI 5; CMPI 6 -> accu=5, C=0, Z=0.
- LDI 9; ST 0x123 -> ram_we=1 for one cycle with ram_addr=0x123, ram_wdata=9. LDI 0; LD 0x123 (RAM model returns 9) -> accu=9.
- pushbuttons=0110; IN; OUT -> out_port=6. JNZ 0x040 -> pc=0x040. pushbuttons=0000; IN; JNZ -> not taken.
- Four nested CALLs then four RETs -> sp goes 1..4..0 and pc returns to each call+1. A fifth nested CALL -> fault=1, pc frozen, sp=4. A RET at sp=0 -> fault=1.
- run=0 at reset -> pc stays 0 for 10 cycles. Assert reset during EXEC of ST -> ram_we drops the same instant and all outputs return to reset values.
